draw_scheduler: RTL and testbench
=================================

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, max DRAW cycles per layer before abort (covers the 160x120 clear).
REQ-002 SHALL have parameter NUM_LAYERS, default 9, number of select codes sequenced (0..8).
REQ-003 SHALL run on one clock and use an asynchronous, active-low reset.
REQ-004 clock  in  1  system clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 frame_tick  in  1  single-cycle request to draw one frame.
REQ-007 endgame  in  1  game over; frame reduces to the clear layer only.
REQ-008 layer_en  in  9  per-select-code enable mask; bit i enables layer i.
REQ-009 layer_done  in  9  per-layer completion pulse from the layer's pixel generator.
REQ-010 select  out  4  layer code driven to the pixel datapath.
REQ-011 output_signal  out  1  datapath write qualifier; high only in DRAW.
REQ-012 layer_start  out  9  one-hot single-cycle start pulse to the active layer generator.
REQ-013 busy  out  1  high from frame accept until frame_done.
REQ-014 frame_done  out  1  single-cycle pulse at frame end.
REQ-015 overrun  out  1  sticky; frame_tick arrived while busy.
REQ-016 timeout_err  out  1  sticky; a layer hit TIMEOUT_CYCLES.

Function
REQ-017 Draw order SHALL be fixed: 1 (clear), 3, 4, 5, 6 (walls), 2 (fruit), 7 (moving fruit), 0 (snake), 8 (snake 2).
REQ-018 FSM states SHALL be IDLE, PICK, START, DRAW, DONE; all outputs Moore-decoded from registered state, position and counter.
REQ-019 IDLE: frame_tick=1 -> PICK next cycle with order position 0, busy=1.
REQ-020 PICK: first enabled layer at or after current position -> START with select=that code; none left -> DONE; PICK lasts exactly one cycle.
REQ-021 When endgame=1 at frame accept, only layer 1 SHALL be considered for the whole frame, regardless of layer_en[1]; endgame changes mid-frame are ignored until the next frame.
REQ-022 START: layer_start[select]=1 and output_signal=0 for exactly one cycle, then DRAW.
REQ-023 DRAW: output_signal=1, select held; layer_done[select]=1 -> PICK with position+1; layer_done bits for other layers ignored.
REQ-024 layer_done asserted during the START cycle SHALL be ignored; the layer is finished only by a done seen in DRAW.
REQ-025 DRAW timeout counter SHALL clear on entering DRAW; when it reaches TIMEOUT_CYCLES-1 without done, set timeout_err and go to PICK with position+1.
REQ-026 Done and timeout in the same cycle SHALL count as done; timeout_err not set.
REQ-027 DONE: frame_done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-028 frame_tick while busy=1, including the DONE cycle, SHALL set overrun and be dropped; no queuing.
REQ-029 layer_en=0 (and endgame=0): frame SHALL be IDLE->PICK->DONE->IDLE, with frame_done two cycles after tick.
REQ-030 In IDLE, PICK and DONE: output_signal=0, layer_start=0; select holds last value.

Reset
REQ-031 resetn low SHALL immediately force IDLE, select=0, output_signal=0, layer_start=0, busy=0, frame_done=0, overrun=0, timeout_err=0, counter=0, position=0.
REQ-032 Reset mid-frame SHALL abandon the frame without emitting frame_done; first frame_tick after release restarts from position 0.

Structure
REQ-033 Package snake_draw_pkg SHALL hold layer code constants (LAYER_SNAKE=0 ... LAYER_SNAKE2=8), the 9-entry DRAW_ORDER table and the FSM state typedef.
REQ-034 Next-enabled-layer search SHALL be one combinational sub-module, next_layer_sel (order position and mask in; found flag, code, position out).

Verification
REQ-035 layer_en=9'h1FF, each done 3 cycles after start -> select sequence 1,3,4,5,6,2,7,0,8; 9 start pulses; frame_done once.
REQ-036 layer_en=9'h003, endgame=1 -> only select=1 drawn, layer_start=9'h002 once, then frame_done.
REQ-037 layer_en=9'h004, TIMEOUT_CYCLES=8, no done -> output_signal high exactly 8 cycles, timeout_err=1, frame_done follows.
REQ-038 frame_tick again 5 cycles after accept -> overrun=1, only one frame_done; second tick after frame_done accepted normally.
REQ-039 resetn pulsed low during layer 4 DRAW -> all outputs 0 immediately, no frame_done; next frame restarts at layer 1.

Source files
------------

// File: rtl/snake_draw_pkg.sv
// Shared definitions for the snake-game draw scheduler.
// Holds layer select codes, the fixed per-frame draw order and the scheduler
// FSM state type. No ports; imported by draw_scheduler and next_layer_sel.
package snake_draw_pkg;

    localparam int unsigned NUM_LAYERS_C = 9;
    localparam int unsigned CODE_W       = 4;
    // Order position runs 0..NUM_LAYERS_C, where NUM_LAYERS_C means "past the end".
    localparam int unsigned POS_W        = 4;

    localparam logic [CODE_W-1:0] LAYER_SNAKE  = 4'd0;
    localparam logic [CODE_W-1:0] LAYER_CLEAR  = 4'd1;
    localparam logic [CODE_W-1:0] LAYER_FRUIT  = 4'd2;
    localparam logic [CODE_W-1:0] LAYER_WALL0  = 4'd3;
    localparam logic [CODE_W-1:0] LAYER_WALL1  = 4'd4;
    localparam logic [CODE_W-1:0] LAYER_WALL2  = 4'd5;
    localparam logic [CODE_W-1:0] LAYER_WALL3  = 4'd6;
    localparam logic [CODE_W-1:0] LAYER_MFRUIT = 4'd7;
    localparam logic [CODE_W-1:0] LAYER_SNAKE2 = 4'd8;

    // Back-to-front painting order: background first, snakes last.
    localparam logic [CODE_W-1:0] DRAW_ORDER [NUM_LAYERS_C] = '{
        LAYER_CLEAR, LAYER_WALL0, LAYER_WALL1, LAYER_WALL2, LAYER_WALL3,
        LAYER_FRUIT, LAYER_MFRUIT, LAYER_SNAKE, LAYER_SNAKE2
    };

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        START,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/next_layer_sel.sv
// Combinational search for the next enabled layer in draw order.
// Ports:
//   pos       in  order position to start searching from (inclusive)
//   mask      in  per-select-code enable mask
//   found     out an enabled layer exists at or after pos
//   code      out select code of that layer
//   found_pos out order position of that layer
module next_layer_sel
    import snake_draw_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = NUM_LAYERS_C
) (
    input  logic [POS_W-1:0]      pos,
    input  logic [NUM_LAYERS-1:0] mask,
    output logic                  found,
    output logic [CODE_W-1:0]     code,
    output logic [POS_W-1:0]      found_pos
);

    // Priority scan: first hit at or after pos wins.
    always_comb begin
        found     = 1'b0;
        code      = '0;
        found_pos = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && (POS_W'(i) >= pos) && mask[DRAW_ORDER[i]]) begin
                found     = 1'b1;
                code      = DRAW_ORDER[i];
                found_pos = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame layer sequencer for the snake-game pixel datapath.
// Walks the fixed draw order, starting each enabled layer generator and
// waiting for its done pulse (or a timeout) before moving on.
// Ports:
//   clock, resetn  system clock, async active-low reset
//   frame_tick     request one frame
//   endgame        game over: frame draws only the clear layer
//   layer_en       per-code enable mask
//   layer_done     per-code completion pulses
//   select         layer code to the datapath
//   output_signal  datapath write qualifier (DRAW only)
//   layer_start    one-hot start pulse for the active layer
//   busy           frame in progress
//   frame_done     end-of-frame pulse
//   overrun        sticky: tick arrived while busy
//   timeout_err    sticky: a layer hit the timeout
module draw_scheduler
    import snake_draw_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned NUM_LAYERS     = 9
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  frame_tick,
    input  logic                  endgame,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [CODE_W-1:0]     select,
    output logic                  output_signal,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    eg_q, eg_d;
    logic [CODE_W-1:0]       select_d;
    logic                    output_signal_d;
    logic [NUM_LAYERS-1:0]   layer_start_d;
    logic                    busy_d;
    logic                    frame_done_d;
    logic                    overrun_d;
    logic                    timeout_err_d;

    logic [NUM_LAYERS-1:0]   search_mask;
    logic                    nl_found;
    logic [CODE_W-1:0]       nl_code;
    logic [POS_W-1:0]        nl_pos;

    // Endgame latched at accept forces a clear-only frame, ignoring layer_en.
    assign search_mask = eg_q ? (NUM_LAYERS'(1) << LAYER_CLEAR) : layer_en;

    next_layer_sel #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_next_layer_sel (
        .pos       (pos_q),
        .mask      (search_mask),
        .found     (nl_found),
        .code      (nl_code),
        .found_pos (nl_pos)
    );

    // State and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            pos_q         <= '0;
            cnt_q         <= '0;
            eg_q          <= 1'b0;
            select        <= '0;
            output_signal <= 1'b0;
            layer_start   <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            cnt_q         <= cnt_d;
            eg_q          <= eg_d;
            select        <= select_d;
            output_signal <= output_signal_d;
            layer_start   <= layer_start_d;
            busy          <= busy_d;
            frame_done    <= frame_done_d;
            overrun       <= overrun_d;
            timeout_err   <= timeout_err_d;
        end
    end

    // Next state; outputs are decoded from the next state so the registered
    // copies line up with the state register (Moore timing).
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        cnt_d         = cnt_q;
        eg_d          = eg_q;
        select_d      = select;
        timeout_err_d = timeout_err;
        overrun_d     = overrun | (frame_tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = PICK;
                    pos_d   = '0;
                    eg_d    = endgame;
                end
            end
            PICK: begin
                if (nl_found) begin
                    state_d  = START;
                    select_d = nl_code;
                    pos_d    = nl_pos;
                end else begin
                    state_d = DONE;
                end
            end
            START: begin
                state_d = DRAW;
                cnt_d   = '0;
            end
            DRAW: begin
                // Done takes priority over a simultaneous timeout.
                if (layer_done[select]) begin
                    state_d = PICK;
                    pos_d   = pos_q + POS_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PICK;
                    pos_d         = pos_q + POS_W'(1);
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        output_signal_d = (state_d == DRAW);
        busy_d          = (state_d != IDLE);
        frame_done_d    = (state_d == DONE);
        layer_start_d   = (state_d == START) ? (NUM_LAYERS'(1) << select_d) : '0;
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: directed frames for the corner
// cases plus randomized frames, all checked against a per-frame reference
// built from the draw order, enable mask and per-layer done delays.
module tb_draw_scheduler;

    localparam int unsigned TMO = 8;
    localparam int unsigned NL  = 9;

    logic          clock      = 1'b0;
    logic          resetn     = 1'b0;
    logic          frame_tick = 1'b0;
    logic          endgame    = 1'b0;
    logic [NL-1:0] layer_en   = '0;
    logic [NL-1:0] layer_done = '0;
    logic [3:0]    select;
    logic          output_signal;
    logic [NL-1:0] layer_start;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic          timeout_err;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_ovr  = 1'b0;
    logic exp_tmo  = 1'b0;
    int   order [9] = '{1, 3, 4, 5, 6, 2, 7, 0, 8};

    always #5 clock = ~clock;

    draw_scheduler #(
        .TIMEOUT_CYCLES (TMO),
        .NUM_LAYERS     (NL)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .endgame       (endgame),
        .layer_en      (layer_en),
        .layer_done    (layer_done),
        .select        (select),
        .output_signal (output_signal),
        .layer_start   (layer_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one frame: called just after a falling edge, drives the tick,
    // answers each layer start with a done after dly[code] DRAW cycles,
    // and compares what was observed with the expected frame.
    task automatic run_frame(input string name, input logic [NL-1:0] en, input logic eg,
                             input int dly [9], input int extra_k);
        int   exp_codes [$];
        int   exp_draws [$];
        int   obs_codes [$];
        int   obs_draws [$];
        int   exp_lat;
        int   done_at;
        int   n_done;
        int   busy_bad;
        int   sel_bad;
        int   draw_cnt;
        int   cur;
        int   k;
        int   d;
        int   oc;
        int   od;
        logic prev_os;

        exp_lat = 2;
        for (int i = 0; i < 9; i++) begin
            if (eg ? (order[i] == 1) : (en[order[i]] == 1'b1)) begin
                d = (dly[order[i]] > int'(TMO)) ? int'(TMO) : dly[order[i]];
                exp_codes.push_back(order[i]);
                exp_draws.push_back(d);
                exp_lat += 2 + d;
                if (dly[order[i]] > int'(TMO)) exp_tmo = 1'b1;
            end
        end
        if (extra_k > exp_lat) extra_k = exp_lat;
        if (extra_k != 0) exp_ovr = 1'b1;

        frame_tick = 1'b1;
        layer_en   = en;
        endgame    = eg;
        done_at  = 0;
        n_done   = 0;
        busy_bad = 0;
        sel_bad  = 0;
        draw_cnt = 0;
        cur      = -1;
        prev_os  = 1'b0;
        k        = 0;
        while (k < 400 && (done_at == 0 || k < done_at + 2)) begin
            @(negedge clock);
            k++;
            if (prev_os && !output_signal) obs_draws.push_back(draw_cnt);
            if (layer_start != '0) begin
                cur = -1;
                for (int b = 0; b < int'(NL); b++) if (layer_start[b]) cur = b;
                check({name, "/start_onehot"}, 32'($onehot(layer_start)), 32'd1);
                check({name, "/start_select"}, 32'(select), 32'(cur));
                obs_codes.push_back(cur);
                draw_cnt = 0;
            end
            if (output_signal) begin
                draw_cnt++;
                if (32'(select) != 32'(cur)) sel_bad++;
            end
            if (frame_done) begin
                n_done++;
                if (done_at == 0) done_at = k;
            end
            if (busy !== (k <= exp_lat)) busy_bad++;
            prev_os = output_signal;

            frame_tick = (k == extra_k);
            endgame    = 1'($urandom);
            layer_done = NL'($urandom);
            if (output_signal && cur >= 0) layer_done[select] = (draw_cnt == dly[cur]);
        end
        frame_tick = 1'b0;
        layer_done = '0;
        endgame    = 1'b0;

        check({name, "/frame_done_count"}, 32'(n_done), 32'd1);
        check({name, "/tick_to_done"}, 32'(done_at), 32'(exp_lat));
        check({name, "/num_starts"}, 32'(obs_codes.size()), 32'(exp_codes.size()));
        for (int i = 0; i < exp_codes.size(); i++) begin
            oc = (i < obs_codes.size()) ? obs_codes[i] : -1;
            od = (i < obs_draws.size()) ? obs_draws[i] : -1;
            check({name, "/layer_code"}, 32'(oc), 32'(exp_codes[i]));
            check({name, "/draw_cycles"}, 32'(od), 32'(exp_draws[i]));
        end
        check({name, "/busy_window_errs"}, 32'(busy_bad), 32'd0);
        check({name, "/select_hold_errs"}, 32'(sel_bad), 32'd0);
        check({name, "/overrun"}, 32'(overrun), 32'(exp_ovr));
        check({name, "/timeout_err"}, 32'(timeout_err), 32'(exp_tmo));
    endtask

    initial begin
        int         dl [9];
        logic [8:0] ren;
        logic       reg_eg;
        int         xk;
        logic       seen;
        logic       stray;

        // Reset values while held in reset.
        #1;
        check("rst/select", 32'(select), 32'd0);
        check("rst/output_signal", 32'(output_signal), 32'd0);
        check("rst/layer_start", 32'(layer_start), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/frame_done", 32'(frame_done), 32'd0);
        check("rst/overrun", 32'(overrun), 32'd0);
        check("rst/timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // No layers enabled: IDLE->PICK->DONE, done two cycles after tick.
        for (int i = 0; i < 9; i++) dl[i] = 3;
        run_frame("empty", 9'h000, 1'b0, dl, 0);

        // All layers, done three cycles after each start.
        run_frame("all", 9'h1FF, 1'b0, dl, 0);

        // Done coinciding with the last timeout cycle counts as done.
        for (int i = 0; i < 9; i++) dl[i] = int'(TMO);
        run_frame("done_at_limit", 9'h011, 1'b0, dl, 0);

        // Endgame: clear layer only, even when it is not enabled.
        for (int i = 0; i < 9; i++) dl[i] = 2;
        run_frame("endgame", 9'h003, 1'b1, dl, 0);
        run_frame("endgame_clr_off", 9'h1FC, 1'b1, dl, 0);

        // Layer that never finishes times out after TMO DRAW cycles.
        for (int i = 0; i < 9; i++) dl[i] = 1000;
        run_frame("timeout", 9'h004, 1'b0, dl, 0);

        // Tick while busy is dropped; the next tick after the frame is taken.
        for (int i = 0; i < 9; i++) dl[i] = 3;
        run_frame("overrun", 9'h1FF, 1'b0, dl, 5);
        run_frame("after_overrun", 9'h1FF, 1'b0, dl, 0);
        run_frame("tick_in_done", 9'h000, 1'b0, dl, 2);

        // Randomized frames.
        for (int f = 0; f < 15; f++) begin
            ren    = 9'($urandom);
            reg_eg = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 9; i++) dl[i] = int'($urandom_range(1, 10));
            xk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_frame("random", ren, reg_eg, dl, xk);
        end

        // Reset during layer 4 DRAW abandons the frame.
        layer_en   = 9'h1FF;
        endgame    = 1'b0;
        frame_tick = 1'b1;
        seen       = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clock);
            frame_tick = 1'b0;
            layer_done = '0;
            if (output_signal && select == 4'd4) seen = 1'b1;
            else if (output_signal) layer_done[select] = 1'b1;
        end
        check("midrst/reached_layer4", 32'(seen), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst/select", 32'(select), 32'd0);
        check("midrst/output_signal", 32'(output_signal), 32'd0);
        check("midrst/layer_start", 32'(layer_start), 32'd0);
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/overrun", 32'(overrun), 32'd0);
        check("midrst/timeout_err", 32'(timeout_err), 32'd0);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (frame_done || busy) stray = 1'b1;
        end
        check("midrst/no_frame_done", 32'(stray), 32'd0);
        resetn  = 1'b1;
        exp_ovr = 1'b0;
        exp_tmo = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 9; i++) dl[i] = int'($urandom_range(1, 6));
        run_frame("after_reset", 9'h1FF, 1'b0, dl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
